// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus slave family.
//   - FSM state encoding used by slave_ram_serial
//   - Default frame geometry (address / data bit counts)
//   - Frame-length helpers, so benches and neighbours agree on timing
package bus_pkg;

  localparam int DEFAULT_ADDR_LEN = 12;
  localparam int DEFAULT_DATA_LEN = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  // Cycles a write frame occupies, from the start cycle through DONE.
  function automatic int write_frame_cycles(input int addr_len, input int data_len);
    return addr_len + data_len + 1;
  endfunction

  // Offset from the start cycle to the first valid read bit when unstalled.
  function automatic int read_first_bit_offset(input int addr_len, input int read_latency);
    return addr_len + read_latency;
  endfunction

  // Width of the shared bit/wait counter: it must hold the largest
  // terminal count of any phase.
  function automatic int counter_width(input int addr_len, input int data_len,
                                       input int read_latency);
    int m;
    m = addr_len;
    if (data_len > m) m = data_len;
    if (read_latency > m) m = read_latency;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/slave_ram_serial_bram.sv
// Single-port synchronous RAM with a registered read port.
// Written so synthesis maps it onto block RAM.
//   clk    system clock
//   we     write enable; wdata stored at addr on the rising edge
//   addr   word address (read and write share it)
//   wdata  write word
//   rdata  word at the address presented on the previous edge (read-first)
module slave_bram #(
  parameter int DATA_LEN  = 8,
  parameter int MEM_DEPTH = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem [MEM_DEPTH];

  // NOTE: the array has no reset; resetting it would stop block-RAM
  // inference, and the slave deliberately keeps contents across reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/slave_ram_serial.sv
// Parametrised serial-bus memory slave for one interconnect slave port.
// Address and write data arrive LSB first, one bit per cycle; read data
// leaves LSB first with per-bit backpressure from the master.
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   read_en        read request, sampled on the start cycle only
//   write_en       write request, sampled on the start cycle only
//   master_valid   master drives a valid address/data bit this cycle
//   master_ready   master accepts the current tx_data bit
//   rx_address     serial address in
//   rx_data        serial write data in
//   slave_ready    high only in IDLE
//   slave_valid    tx_data carries a valid read bit
//   tx_data        serial read data out
//   rx_done        one-cycle pulse: write frame complete
//   slave_tx_done  one-cycle pulse: read frame complete
//   slave_err      pulses with the done pulse when address >= MEM_DEPTH
module slave_ram_serial
  import bus_pkg::*;
#(
  parameter int ADDR_LEN     = DEFAULT_ADDR_LEN,
  parameter int DATA_LEN     = DEFAULT_DATA_LEN,
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_address,
  input  logic rx_data,
  output logic slave_ready,
  output logic slave_valid,
  output logic tx_data,
  output logic rx_done,
  output logic slave_tx_done,
  output logic slave_err
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = counter_width(ADDR_LEN, DATA_LEN, READ_LATENCY);
  localparam logic [ADDR_LEN:0] DEPTH_LIMIT = (ADDR_LEN + 1)'(MEM_DEPTH);

  state_t              state;
  logic                is_write;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_LEN-1:0] addr_sr;
  logic [DATA_LEN-1:0] wdata_sr;
  logic [DATA_LEN-1:0] tx_sr;

  logic [ADDR_LEN-1:0] addr_next;
  logic [DATA_LEN-1:0] wdata_next;
  logic [DATA_LEN-1:0] ram_rdata;
  logic [DATA_LEN-1:0] rd_word;
  logic [RAM_AW-1:0]   ram_addr;
  logic                ram_we;
  logic                addr_oor;
  logic                start;
  logic                last_addr_bit;
  logic                last_data_bit;
  logic                last_wait;

  // Bits shift in at the MSB end so that, after ADDR_LEN / DATA_LEN
  // shifts, the first (LSB) bit ends up in position 0.
  assign addr_next  = {rx_address, addr_sr[ADDR_LEN-1:1]};
  assign wdata_next = {rx_data, wdata_sr[DATA_LEN-1:1]};

  // Compare on one extra bit so MEM_DEPTH == 2**ADDR_LEN never flags.
  assign addr_oor = {1'b0, addr_sr} >= DEPTH_LIMIT;

  assign start         = master_valid & (read_en ^ write_en);
  assign last_addr_bit = (cnt == CNT_W'(ADDR_LEN - 1));
  assign last_data_bit = (cnt == CNT_W'(DATA_LEN - 1));
  assign last_wait     = (cnt == CNT_W'(READ_LATENCY - 1));

  // During ADDR the RAM sees the address including the bit arriving this
  // cycle, so the registered read word is ready on the first WAIT cycle
  // and READ_LATENCY = 1 still works.
  assign ram_addr = (state == S_ADDR) ? addr_next[RAM_AW-1:0] : addr_sr[RAM_AW-1:0];

  // The write edge is the one capturing the last data bit; a reset on that
  // same edge must still drop the partial frame.
  assign ram_we = !reset && (state == S_WDATA) && master_valid && last_data_bit && !addr_oor;

  assign rd_word = addr_oor ? '1 : ram_rdata;

  slave_bram #(
    .DATA_LEN  (DATA_LEN),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (RAM_AW)
  ) u_bram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_next),
    .rdata (ram_rdata)
  );

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      is_write      <= 1'b0;
      cnt           <= '0;
      addr_sr       <= '0;
      wdata_sr      <= '0;
      tx_sr         <= '0;
      slave_ready   <= 1'b1;
      slave_valid   <= 1'b0;
      tx_data       <= 1'b0;
      rx_done       <= 1'b0;
      slave_tx_done <= 1'b0;
      slave_err     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_sr     <= addr_next;
            is_write    <= write_en;
            cnt         <= CNT_W'(1);
            slave_ready <= 1'b0;
            state       <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (!master_valid) begin
            slave_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            addr_sr <= addr_next;
            if (last_addr_bit) begin
              cnt   <= '0;
              state <= is_write ? S_WDATA : S_WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_WDATA: begin
          if (!master_valid) begin
            slave_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wdata_sr <= wdata_next;
            if (last_data_bit) begin
              cnt       <= '0;
              rx_done   <= 1'b1;
              slave_err <= addr_oor;
              state     <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (last_wait) begin
            tx_data     <= rd_word[0];
            tx_sr       <= rd_word >> 1;
            slave_valid <= 1'b1;
            cnt         <= '0;
            state       <= S_SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SEND: begin
          if (master_ready) begin
            if (last_data_bit) begin
              slave_valid   <= 1'b0;
              tx_data       <= 1'b0;
              slave_tx_done <= 1'b1;
              slave_err     <= addr_oor;
              cnt           <= '0;
              state         <= S_DONE;
            end else begin
              tx_data <= tx_sr[0];
              tx_sr   <= tx_sr >> 1;
              cnt     <= cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          rx_done       <= 1'b0;
          slave_tx_done <= 1'b0;
          slave_err     <= 1'b0;
          slave_ready   <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          slave_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
